// File: rtl/superscalar_fwd_hazard_unit_pkg.sv
// Shared types and select-code helpers for the superscalar forwarding/hazard unit.
package fwd_pkg;
  typedef enum logic {IDLE, STALL} state_e;

  localparam int SEL_RF = 0;

  // Select code for forwarding source (stage, lane); 0 is reserved for the register file.
  function automatic int sel_code(input int stage, input int lane, input int lanes);
    return 1 + stage * lanes + lane;
  endfunction
endpackage

// File: rtl/superscalar_fwd_hazard_unit_select.sv
// One operand's bypass-select priority encoder over all STAGES*LANES forwarding sources.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int REG_W  = 5,
  parameter int SEL_W  = 3
) (
  input  logic [REG_W-1:0]                    idx,
  input  logic [STAGES*LANES-1:0][REG_W-1:0]  wr_reg,
  input  logic [STAGES*LANES-1:0]             reg_write,
  output logic [SEL_W-1:0]                    sel
);
  // Scan oldest-to-youngest so the last hit (lowest stage, highest lane) wins.
  always_comb begin
    sel = SEL_W'(SEL_RF);
    for (int s = STAGES - 1; s >= 0; s--)
      for (int l = 0; l < LANES; l++)
        if (reg_write[s*LANES+l] && wr_reg[s*LANES+l] == idx && idx != '0)
          sel = SEL_W'(sel_code(s, l, LANES));
  end
endmodule

// File: rtl/superscalar_fwd_hazard_unit.sv
// N-lane bypass-select generator with a multi-cycle load-use stall FSM.
// Optional counters stall_cycles/fwd_events under macro FWD_HAZARD_STATS_EN.
module superscalar_fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int STAGES   = 2,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [LANES*REG_W-1:0]                        rsE,
  input  logic [LANES*REG_W-1:0]                        rtE,
  input  logic [STAGES*LANES*REG_W-1:0]                 wrRegS,
  input  logic [STAGES*LANES-1:0]                       regWriteS,
  input  logic [LANES*REG_W-1:0]                        rsD,
  input  logic [LANES*REG_W-1:0]                        rtD,
  input  logic [LANES*REG_W-1:0]                        wrRegE,
  input  logic [LANES-1:0]                              regWriteE,
  input  logic [LANES-1:0]                              memReadE,
  input  logic                                          flush_i,
  output logic [LANES*$clog2(LANES*STAGES+1)-1:0]       fwdA,
  output logic [LANES*$clog2(LANES*STAGES+1)-1:0]       fwdB,
  output logic                                          stallF,
  output logic                                          stallD,
  output logic                                          flushE,
  output logic                                          stall_busy
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                                   stall_cycles,
  output logic [31:0]                                   fwd_events
`endif
);
  localparam int SEL_W = $clog2(LANES * STAGES + 1);
  localparam int CNT_W = 3;

  logic [LANES-1:0][REG_W-1:0]        rs_e, rt_e, rs_d, rt_d, wr_e;
  logic [STAGES*LANES-1:0][REG_W-1:0] wr_s;
  logic [LANES-1:0][SEL_W-1:0]        sel_a, sel_b;

  assign rs_e = rsE;
  assign rt_e = rtE;
  assign rs_d = rsD;
  assign rt_d = rtD;
  assign wr_e = wrRegE;
  assign wr_s = wrRegS;
  assign fwdA = sel_a;
  assign fwdB = sel_b;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fwd_select #(.LANES(LANES), .STAGES(STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_a (
      .idx(rs_e[l]), .wr_reg(wr_s), .reg_write(regWriteS), .sel(sel_a[l])
    );
    fwd_select #(.LANES(LANES), .STAGES(STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_b (
      .idx(rt_e[l]), .wr_reg(wr_s), .reg_write(regWriteS), .sel(sel_b[l])
    );
  end

  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LANES; j++)
        if (regWriteE[i] && memReadE[i] && wr_e[i] != '0 &&
            (wr_e[i] == rs_d[j] || wr_e[i] == rt_d[j]))
          hit = 1'b1;
  end

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             stall_req;

  // While STALL the hit input is ignored; flush overrides stalls but always flushes EX.
  assign stall_req  = (state == STALL) || hit;
  assign stallF     = stall_req && !flush_i;
  assign stallD     = stall_req && !flush_i;
  assign flushE     = stall_req || flush_i;
  assign stall_busy = (state == STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (hit && LOAD_LAT > 1) begin
          state <= STALL;
          cnt   <= CNT_W'(LOAD_LAT - 1);
        end
        STALL: if (cnt == CNT_W'(1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [3:0]  n_fwd;
  logic [32:0] fwd_sum;
  always_comb begin
    n_fwd = '0;
    for (int l = 0; l < LANES; l++)
      n_fwd = n_fwd + 4'(sel_a[l] != '0) + 4'(sel_b[l] != '0);
  end
  assign fwd_sum = {1'b0, fwd_events} + 33'(n_fwd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stallD && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      fwd_events <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_superscalar_fwd_hazard_unit.sv
// Scoreboard bench: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus; monitor checks at negedge.
module tb_superscalar_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][4:0] rsE, rtE, rsD, rtD, wrRegE;
  logic [3:0][4:0] wrRegS;
  logic [3:0]      regWriteS;
  logic [1:0]      regWriteE, memReadE;
  logic            flush_i;

  logic [5:0] fa1, fb1, fa3, fb3;
  logic       sf1, sd1, fe1, sb1, sf3, sd3, fe3, sb3;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] sc1, ev1, sc3, ev3;
`endif

  superscalar_fwd_hazard_unit #(.LANES(2), .STAGES(2), .REG_W(5), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rsE(rsE), .rtE(rtE), .wrRegS(wrRegS), .regWriteS(regWriteS),
    .rsD(rsD), .rtD(rtD), .wrRegE(wrRegE), .regWriteE(regWriteE), .memReadE(memReadE),
    .flush_i(flush_i), .fwdA(fa1), .fwdB(fb1), .stallF(sf1), .stallD(sd1), .flushE(fe1),
    .stall_busy(sb1)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(sc1), .fwd_events(ev1)
`endif
  );

  superscalar_fwd_hazard_unit #(.LANES(2), .STAGES(2), .REG_W(5), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .rsE(rsE), .rtE(rtE), .wrRegS(wrRegS), .regWriteS(regWriteS),
    .rsD(rsD), .rtD(rtD), .wrRegE(wrRegE), .regWriteE(regWriteE), .memReadE(memReadE),
    .flush_i(flush_i), .fwdA(fa3), .fwdB(fb3), .stallF(sf3), .stallD(sd3), .flushE(fe3),
    .stall_busy(sb3)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(sc3), .fwd_events(ev3)
`endif
  );

  typedef struct {
    string       nm;
    logic [5:0]  fa, fb;
    logic [3:0]  c1, c3;  // {stallF, stallD, flushE, stall_busy}
    bit          st;
    logic [31:0] sc, fe;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, "/fwdA1"}, 32'(fa1), 32'(e.fa));
      chk({e.nm, "/fwdB1"}, 32'(fb1), 32'(e.fb));
      chk({e.nm, "/fwdA3"}, 32'(fa3), 32'(e.fa));
      chk({e.nm, "/fwdB3"}, 32'(fb3), 32'(e.fb));
      chk({e.nm, "/ctl1"}, 32'({sf1, sd1, fe1, sb1}), 32'(e.c1));
      chk({e.nm, "/ctl3"}, 32'({sf3, sd3, fe3, sb3}), 32'(e.c3));
`ifdef FWD_HAZARD_STATS_EN
      if (e.st) begin
        chk({e.nm, "/stall_cycles"}, sc3, e.sc);
        chk({e.nm, "/fwd_events"}, ev3, e.fe);
      end
`endif
    end
  end

  task automatic clr();
    rsE = '0; rtE = '0; rsD = '0; rtD = '0; wrRegE = '0; wrRegS = '0;
    regWriteS = '0; regWriteE = '0; memReadE = '0; flush_i = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic push(input string nm, input logic [5:0] fa, input logic [5:0] fb,
                      input logic [3:0] c1, input logic [3:0] c3,
                      input bit st = 1'b0, input int sc = 0, input int fe = 0);
    exp_t e;
    e.nm = nm; e.fa = fa; e.fb = fb; e.c1 = c1; e.c3 = c3;
    e.st = st; e.sc = 32'(sc); e.fe = 32'(fe);
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    nxt(); push("reset", 6'h00, 6'h00, 4'b0000, 4'b0000);
    // Forwarding priority
    nxt(); rst_n = 1'b1;
    rsE[0] = 5; wrRegS[0] = 5; wrRegS[1] = 5; regWriteS = 4'b0011;
    push("prio_lane", 6'h02, 6'h00, 4'b0000, 4'b0000);
    nxt(); rsE[0] = 5; wrRegS[2] = 5; regWriteS = 4'b0100;
    push("stage1_only", 6'h03, 6'h00, 4'b0000, 4'b0000);
    nxt(); regWriteS = 4'hF;
    push("reg0", 6'h00, 6'h00, 4'b0000, 4'b0000);
    nxt(); rsE[1] = 9; rtE[1] = 9; wrRegS[0] = 9; wrRegS[1] = 9; wrRegS[3] = 9; regWriteS = 4'b1001;
    push("stage_pri", 6'h08, 6'h08, 4'b0000, 4'b0000);
    nxt(); rsE[0] = 12; wrRegS[2] = 12; wrRegS[3] = 12; regWriteS = 4'b1100;
    push("lane_pri_s1", 6'h04, 6'h00, 4'b0000, 4'b0000);
    // Non-hits
    nxt(); memReadE[0] = 1; wrRegE[0] = 3; rsD[1] = 3;
    push("no_we", 6'h00, 6'h00, 4'b0000, 4'b0000);
    nxt(); regWriteE[1] = 1; memReadE[1] = 1;
    push("load_r0", 6'h00, 6'h00, 4'b0000, 4'b0000);
    // Load-use stall lengths
    nxt(); regWriteE[1] = 1; memReadE[1] = 1; wrRegE[1] = 7; rsD[0] = 7;
    push("lu_c1", 6'h00, 6'h00, 4'b1110, 4'b1110);
    nxt(); push("lu_c2", 6'h00, 6'h00, 4'b0000, 4'b1111);
    nxt(); push("lu_c3", 6'h00, 6'h00, 4'b0000, 4'b1111);
    nxt(); push("lu_c4", 6'h00, 6'h00, 4'b0000, 4'b0000, 1'b1, 3, 5);
    // Flush mid-stall
    nxt(); regWriteE[0] = 1; memReadE[0] = 1; wrRegE[0] = 8; rtD[1] = 8;
    push("fm_c1", 6'h00, 6'h00, 4'b1110, 4'b1110);
    nxt(); flush_i = 1'b1;
    push("fm_c2", 6'h00, 6'h00, 4'b0010, 4'b0011);
    nxt(); push("fm_c3", 6'h00, 6'h00, 4'b0000, 4'b0000);
    // Flush coinciding with a hit in IDLE
    nxt(); regWriteE[0] = 1; memReadE[0] = 1; wrRegE[0] = 8; rtD[1] = 8; flush_i = 1'b1;
    push("fi_c1", 6'h00, 6'h00, 4'b0010, 4'b0010);
    nxt(); push("fi_c2", 6'h00, 6'h00, 4'b0000, 4'b0000);
    // Asynchronous reset mid-stall
    nxt(); regWriteE[1] = 1; memReadE[1] = 1; wrRegE[1] = 7; rtD[0] = 7;
    push("rm_c1", 6'h00, 6'h00, 4'b1110, 4'b1110);
    nxt(); push("rm_c2", 6'h00, 6'h00, 4'b0000, 4'b1111);
    nxt(); rst_n = 1'b0;
    push("rm_rst", 6'h00, 6'h00, 4'b0000, 4'b0000);
    nxt(); rst_n = 1'b1;
    push("rm_rel", 6'h00, 6'h00, 4'b0000, 4'b0000);
    nxt(); push("rm_c5", 6'h00, 6'h00, 4'b0000, 4'b0000);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
